sorted_ram_writer: RTL and testbench
====================================

# sorted_ram_writer

- Writer-side counterpart of the binary-search datapath: builds and holds the sorted 32 × 8 table that the search block reads through `loc`/`curr`.
- Accepts values one at a time over a valid/ready handshake and inserts each one in ascending order, shifting larger entries up one slot per cycle.
- Presents a combinational read port for the search datapath.

## Interface
- `DEPTH`, default 32: number of table entries.
- `DW`, default 8: entry width.
- `AW`, default 5: address width, equal to log2(`DEPTH`).
- `clk` input, 1: system clock; all state changes on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in_valid` input, 1: `in_data` holds a value to insert.
- `in_data` input, `DW`: value to insert.
- `in_ready` output, 1: block can accept a value this cycle.
- `rd_addr` input, `AW`: read address, driven by the search datapath's `loc`.
- `rd_data` output, `DW`: the entry at `rd_addr`; feeds the search datapath's `curr`.
- `count` output, `AW`+1: number of valid entries, 0..32.
- `full` output, 1: `count` == `DEPTH`.
- `busy` output, 1: an insertion is in progress; table contents are transient.

## Operation
- **Reset:**
  - All entries become 8'hFF (EMPTY_VAL), so unused slots sort above every real value and a full 0..31 search window stays valid.
  - `count` = 0, state = IDLE, `busy` = 0, `full` = 0, `in_ready` = 1.
- **IDLE:**
  - `in_ready` = !`full`.
  - A transfer happens when `in_valid` && `in_ready` on a rising edge. At that edge: latch v = `in_data`, set index i = `count`, go to SHIFT.
- **SHIFT, one comparison per cycle:**
  - If i > 0 and mem[i-1] > v: mem[i] <= mem[i-1] and i <= i-1. Stay in SHIFT.
  - Otherwise: mem[i] <= v, `count` <= `count`+1, go to IDLE.
- **Duplicates:** the compare is strictly greater-than. A new value lands after existing equal values, so insertion is stable.
- **Value 8'hFF:** inserting it is legal. It occupies slot `count` without any shifts.
- **Full:** at `count` = 32, `in_ready` stays 0. `in_valid` is ignored and the value is neither dropped silently nor accepted; the producer must hold it.
- **Read port:**
  - `rd_data` = mem[`rd_addr`], purely combinational with no latency.
  - While `busy` = 1 the table holds a duplicated entry. The search controller must not start while `busy` = 1.
- **Reset mid-insertion:** aborts immediately. The table returns to all 8'hFF and `count` to 0, with no partial result retained.

## Timing
- Accept at edge T. SHIFT cycles run T+1 .. T+k+1, where k is the number of entries greater than v.
- The final write occurs at edge T+k+1. `count` and the full table are valid from T+k+1 onward.
- `busy` is high from T+1 through the cycle ending at edge T+k+1. `in_ready` is 0 over the same cycles.
- Worst-case occupancy: 32 cycles (31 shifts + 1 write). Minimum: 1 cycle.
- `in_ready` depends only on registered state and never on `in_valid`, so there is no combinational path from input to ready.
- Back-to-back inserts: the next accept happens at earliest edge T+k+2.

## Configuration
- **`SORTED_WRITER_CLEAR_EN` defined:**
  - Adds input `clear` (1 bit).
  - `clear` = 1 in IDLE sets every entry to 8'hFF and `count` to 0 at the next edge.
  - `clear` has priority over a simultaneous `in_valid` accept; that value is not taken and `in_ready` is 0 that cycle.
  - `clear` is ignored while `busy`.
- **Not defined:** there is no `clear` port, and the table empties only through `rst_n`.

## Structure
- **Package `sorted_mem_pkg`:**
  - Constants `DEPTH`, `DW`, `AW`, `EMPTY_VAL` = 8'hFF.
  - `typedef enum logic {IDLE, SHIFT} wr_state_t`.
  - Shared with the search datapath/controller so table geometry stays consistent.
- **Sub-modules:** none is natural. The shift needs every entry's register written in parallel, so the storage is a flat register array inside this module rather than a separate RAM block.

## Test plan
- **Reset:** assert `rst_n`=0, then release. Require `count`=0, `full`=0, `in_ready`=1, `busy`=0, and `rd_data`=8'hFF for every `rd_addr` 0..31.
- **Ascending inserts:** insert 10, 20, 30. Each completes in 1 busy cycle. Require mem[0..2] = 10, 20, 30 and `count`=3.
- **Shifted insert:** insert 5 into {10,20,30}. Require 4 busy cycles and final mem[0..3] = 5, 10, 20, 30.
- **Duplicate and 8'hFF values:** insert 20 into {10,20,30}, giving {10,20,20,30}. Then insert 8'hFF; it lands at slot 4 with 1 busy cycle.
- **Full:** insert 32 values 31..0 in that order. The last insert takes 32 busy cycles. Require mem[i]=i, `full`=1, and `in_ready`=0. Assert `in_valid` with 7 and require no change to the table.
- **Reset mid-operation:** during the shift phase of inserting 0 into 20 entries, pulse `rst_n` low. Require an immediate all-8'hFF table and `count`=0. With `SORTED_WRITER_CLEAR_EN` defined, repeat using `clear` in IDLE and require the same result one cycle later.

Source files
------------

// File: rtl/sorted_mem_pkg.sv
// Shared geometry and writer state encoding for the sorted table and its search datapath.
package sorted_mem_pkg;

    localparam int DEPTH = 32;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam logic [7:0] EMPTY_VAL = 8'hFF;

    typedef enum logic {IDLE, SHIFT} wr_state_t;

endpackage

// File: rtl/sorted_ram_writer.sv
// Sorted-insert writer: keeps an ascending table, shifting larger entries up one slot per cycle.
// Optional feature: define SORTED_WRITER_CLEAR_EN to add a `clear` input that empties the table from IDLE.
module sorted_ram_writer #(
    parameter int DEPTH = sorted_mem_pkg::DEPTH,
    parameter int DW = sorted_mem_pkg::DW,
    parameter int AW = sorted_mem_pkg::AW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic [DW-1:0] in_data,
    output logic in_ready,
`ifdef SORTED_WRITER_CLEAR_EN
    input  logic clear,
`endif
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [AW:0] count,
    output logic full,
    output logic busy,
    output sorted_mem_pkg::wr_state_t state
);
    import sorted_mem_pkg::*;

    // Handshake: a value is taken on a rising edge where in_valid && in_ready;
    // in_ready is derived only from registered state, never from in_valid.

    // All-ones is EMPTY_VAL, so empty slots sort above every real value.
    localparam logic [DW-1:0] EMPTY = {DW{1'b1}};

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] val;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_m1;

    assign idx_m1  = idx - 1'b1;
    assign full    = (count == (AW+1)'(DEPTH));
    assign busy    = (state == SHIFT);
    assign rd_data = mem[rd_addr];

`ifdef SORTED_WRITER_CLEAR_EN
    assign in_ready = (state == IDLE) && !full && !clear;
`else
    assign in_ready = (state == IDLE) && !full;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) mem[j] <= EMPTY;
            count <= '0;
            val   <= '0;
            idx   <= '0;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
`ifdef SORTED_WRITER_CLEAR_EN
                    if (clear) begin
                        for (int j = 0; j < DEPTH; j++) mem[j] <= EMPTY;
                        count <= '0;
                    end else
`endif
                    if (in_valid && in_ready) begin
                        val   <= in_data;
                        idx   <= count[AW-1:0];
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Strict > keeps equal values in arrival order.
                    if (idx != '0 && mem[idx_m1] > val) begin
                        mem[idx] <= mem[idx_m1];
                        idx      <= idx_m1;
                    end else begin
                        mem[idx] <= val;
                        count    <= count + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sorted_ram_writer.sv
// Directed bench for sorted_ram_writer with an independent sorted-list model and expected-value queue.
module tb_sorted_ram_writer;
    import sorted_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic in_ready;
    logic [4:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic [5:0] count;
    logic full;
    logic busy;
    wr_state_t state;
`ifdef SORTED_WRITER_CLEAR_EN
    logic clear = 1'b0;
`endif

    int n_assert = 0;
    int n_fail = 0;
    int model_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    sorted_ram_writer dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
`ifdef SORTED_WRITER_CLEAR_EN
        .clear(clear),
`endif
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .count(count),
        .full(full),
        .busy(busy),
        .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
    endtask

    // Model: count entries strictly greater, insert after the last entry <= v.
    function automatic int model_insert(input int v);
        int k = 0;
        int pos = model_q.size();
        for (int i = 0; i < model_q.size(); i++) if (model_q[i] > v) k++;
        for (int i = model_q.size() - 1; i >= 0; i--) if (model_q[i] > v) pos = i;
        model_q.insert(pos, v);
        return k + 1;
    endfunction

    task automatic push_table();
        for (int i = 0; i < 32; i++)
            exp_q.push_back(i < model_q.size() ? 8'(model_q[i]) : 8'hFF);
    endtask

    task automatic check_table(input string tag);
        logic [7:0] e;
        push_table();
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            #1;
            e = exp_q.pop_front();
            if (rd_data !== e) check({tag, "_entry"}, {24'd0, rd_data}, {24'd0, e});
        end
        n_assert++;
        check({tag, "_count"}, {26'd0, count}, 32'(model_q.size()));
        check({tag, "_full"}, {31'd0, full}, {31'd0, model_q.size() == 32});
    endtask

    task automatic insert(input logic [7:0] v);
        int exp_busy;
        int cyc = 0;
        @(negedge clk);
        check("ready_before", {31'd0, in_ready}, 32'd1);
        exp_busy = model_insert(v);
        in_valid = 1'b1;
        in_data = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        while (busy && cyc < 40) begin
            check("ready_while_busy", {31'd0, in_ready}, 32'd0);
            cyc++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", 32'(cyc), 32'(exp_busy));
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {31'd0, state}, {31'd0, IDLE});
        check_table("rst");

        // Ascending inserts then a shifted insert
        insert(8'd10);
        insert(8'd20);
        insert(8'd30);
        check_table("ascending");
        insert(8'd5);
        check_table("shifted");

        // Duplicate and all-ones values
        do_reset();
        insert(8'd10);
        insert(8'd20);
        insert(8'd30);
        insert(8'd20);
        check_table("duplicate");
        insert(8'hFF);
        check_table("ff_value");

        // Fill with 31..0, last insert shifts 31 entries
        do_reset();
        for (int v = 31; v >= 0; v--) insert(8'(v));
        check_table("full_table");
        @(negedge clk);
        check("full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data = 8'd7;
        repeat (4) begin
            @(negedge clk);
            check("full_hold_busy", {31'd0, busy}, 32'd0);
        end
        in_valid = 1'b0;
        check_table("full_unchanged");

        // Reset during the shift phase
        do_reset();
        for (int v = 1; v <= 20; v++) insert(8'(v));
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        model_q.delete();
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_table("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready", {31'd0, in_ready}, 32'd1);

`ifdef SORTED_WRITER_CLEAR_EN
        for (int v = 1; v <= 20; v++) insert(8'(v));
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 8'd0;
        #1;
        check("clear_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        model_q.delete();
        check("clear_busy", {31'd0, busy}, 32'd0);
        check_table("clear");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
